// File: rtl/b_lut_iter.sv
// b_lut_iter: iterative nibble lookup unit.
// Replaces every 4-bit nibble of crs1 with an entry from a 16 x 4-bit table
// given as {crs3, crs2} (entry i = bits [4i+3:4i]). NPC nibbles are translated
// per BUSY cycle, so a full operation takes G = XLEN/(4*NPC) cycles.
//
// Ports:
//   g_clk, g_resetn      clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (crs1, crs2, crs3 captured on accept)
//   crs1                 XLEN-bit input nibbles
//   crs2, crs3           table entries 0..7 and 8..15
//   flush                abort; forces IDLE, highest priority
//   rsp_valid/rsp_ready  response handshake
//   result               translated word (meaningful while rsp_valid is high)
module b_lut_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NPC  = 2
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] crs1,
    input  logic [31:0]     crs2,
    input  logic [31:0]     crs3,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned G  = XLEN / (4 * NPC);
    localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] CntLast = CW'(G - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] crs1_q, crs1_d;
    logic [63:0]     tbl_q, tbl_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [3:0]      nib;

    assign req_ready = (state_q == StIdle) && !flush;
    assign rsp_valid = rsp_valid_q;
    assign result    = res_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        crs1_d  = crs1_q;
        tbl_d   = tbl_q;
        nib     = 4'h0;

        if (flush) begin
            // result deliberately keeps its last value on abort
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        crs1_d  = crs1;
                        tbl_d   = {crs3, crs2};
                        res_d   = '0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    // translate group cnt_q: nibbles cnt_q*NPC .. cnt_q*NPC+NPC-1
                    for (int unsigned i = 0; i < NPC; i++) begin
                        nib = crs1_q[4 * (int'(cnt_q) * NPC + i) +: 4];
                        res_d[4 * (int'(cnt_q) * NPC + i) +: 4] = tbl_q[4 * int'(nib) +: 4];
                    end
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        rsp_valid_d = (state_d == StDone);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            res_q       <= '0;
            crs1_q      <= '0;
            tbl_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            crs1_q      <= crs1_d;
            tbl_q       <= tbl_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_b_lut_iter.sv
// Testbench for b_lut_iter: three instances (XLEN/NPC = 32/2, 32/8, 64/4) share
// stimulus; results and latencies are compared against a nibble-lookup model.
module tb_b_lut_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] crs1 = '0;
    logic [31:0] crs2 = '0;
    logic [31:0] crs3 = '0;

    logic        rr_a, rr_b, rr_c;
    logic        rv_a, rv_b, rv_c;
    logic [31:0] res_a, res_b;
    logic [63:0] res_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    b_lut_iter #(.XLEN(32), .NPC(2)) u_a (
        .g_clk(clk), .g_resetn(rstn), .req_valid(req_valid), .req_ready(rr_a),
        .crs1(crs1[31:0]), .crs2(crs2), .crs3(crs3), .flush(flush),
        .rsp_valid(rv_a), .rsp_ready(rsp_ready), .result(res_a)
    );
    b_lut_iter #(.XLEN(32), .NPC(8)) u_b (
        .g_clk(clk), .g_resetn(rstn), .req_valid(req_valid), .req_ready(rr_b),
        .crs1(crs1[31:0]), .crs2(crs2), .crs3(crs3), .flush(flush),
        .rsp_valid(rv_b), .rsp_ready(rsp_ready), .result(res_b)
    );
    b_lut_iter #(.XLEN(64), .NPC(4)) u_c (
        .g_clk(clk), .g_resetn(rstn), .req_valid(req_valid), .req_ready(rr_c),
        .crs1(crs1), .crs2(crs2), .crs3(crs3), .flush(flush),
        .rsp_valid(rv_c), .rsp_ready(rsp_ready), .result(res_c)
    );

    // Reference: each nibble of x selects a 4-bit entry of table t.
    function automatic logic [63:0] ref_lut(input logic [63:0] x, input logic [63:0] t,
                                            input int nibs);
        logic [63:0] r = '0;
        for (int i = 0; i < nibs; i++) begin
            r = r | (((t >> (4 * ((x >> (4 * i)) & 64'hf))) & 64'hf) << (4 * i));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait with rsp_ready low (backpressure), then consume.
    task automatic run_op(input logic [63:0] c1, input logic [31:0] c2, input logic [31:0] c3,
                          input bit toggle);
        int lat_a = -1, lat_b = -1, lat_c = -1;
        logic [63:0] held_a = '0, held_c = '0;
        logic [63:0] tbl;
        bit rr_seen = 1'b0;
        tbl = {c3, c2};
        crs1 = c1; crs2 = c2; crs3 = c3;
        req_valid = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rv_a && lat_a < 0) begin lat_a = j; held_a = {32'h0, res_a}; end
            if (rv_b && lat_b < 0) lat_b = j;
            if (rv_c && lat_c < 0) begin lat_c = j; held_c = res_c; end
            if (rr_a || rr_b || rr_c) rr_seen = 1'b1;
            if (toggle) begin
                crs1 = {$urandom, $urandom}; crs2 = $urandom; crs3 = $urandom;
            end
        end
        check("lat_a", 64'(lat_a), 64'd4);
        check("lat_b", 64'(lat_b), 64'd1);
        check("lat_c", 64'(lat_c), 64'd4);
        check("req_ready_low_while_busy_done", {63'h0, rr_seen}, 64'h0);
        check("rsp_valid_held", {61'h0, rv_a, rv_b, rv_c}, 64'h7);
        check("res_a", {32'h0, res_a}, ref_lut(c1, tbl, 8));
        check("res_b", {32'h0, res_b}, ref_lut(c1, tbl, 8));
        check("res_c", res_c, ref_lut(c1, tbl, 16));
        check("res_a_stable", {32'h0, res_a}, held_a);
        check("res_c_stable", res_c, held_c);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", {58'h0, rv_a, rv_b, rv_c, rr_a, rr_b, rr_c}, 64'h7);
    endtask

    initial begin
        logic [63:0] r1;
        logic [31:0] r2, r3;

        // Reset state
        #1;
        check("rst_result_a", {32'h0, res_a}, 64'h0);
        check("rst_result_c", res_c, 64'h0);
        check("rst_rsp_valid", {61'h0, rv_a, rv_b, rv_c}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", {61'h0, rr_a, rr_b, rr_c}, 64'h7);

        // Identity table
        run_op(64'h01234567_01234567, 32'h76543210, 32'hfedcba98, 1'b0);
        check("ident_a", {32'h0, res_a}, 64'h01234567);
        check("ident_c", res_c, 64'h0123456701234567);
        run_op(64'h0123456789abcdef, 32'h76543210, 32'hfedcba98, 1'b0);
        check("ident64_c", res_c, 64'h0123456789abcdef);

        // Reversal table
        run_op(64'h0000_0000_0123_45a7, 32'h89abcdef, 32'h01234567, 1'b0);
        check("rev_a", {32'h0, res_a}, 64'hfedcba58);
        check("rev_b", {32'h0, res_b}, 64'hfedcba58);

        // Inputs toggled during BUSY must not affect the result
        run_op(64'hdeadbeef_12345678, 32'h13572468, 32'h9bdface0, 1'b1);

        // Flush on the 2nd BUSY cycle
        crs1 = 64'h0123456789abcdef; crs2 = 32'h76543210; crs3 = 32'hfedcba98;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", {58'h0, rv_a, rv_b, rv_c, rr_a, rr_b, rr_c}, 64'h7);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("flush_no_rsp", {61'h0, rv_a, rv_b, rv_c}, 64'h0);
        end
        run_op(64'h13579bdf_13579bdf, 32'haaaaaaaa, 32'haaaaaaaa, 1'b0);
        check("const_a", {32'h0, res_a}, 64'haaaaaaaa);
        check("const_c", res_c, 64'haaaaaaaaaaaaaaaa);

        // Asynchronous reset mid-BUSY
        crs1 = 64'hfedcba9876543210; crs2 = 32'h89abcdef; crs3 = 32'h01234567;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("amid_rst_rsp_valid", {61'h0, rv_a, rv_b, rv_c}, 64'h0);
        check("amid_rst_res_a", {32'h0, res_a}, 64'h0);
        check("amid_rst_res_c", res_c, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst2", {61'h0, rr_a, rr_b, rr_c}, 64'h7);

        // Back-to-back random operations
        for (int n = 0; n < 8; n++) begin
            r1 = {$urandom, $urandom}; r2 = $urandom; r3 = $urandom;
            run_op(r1, r2, r3, n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
